sprite_draw_engine: RTL

- Writer side of the CHIP-8 VRAM, executing the DXYN draw instruction.
- Fetches N sprite bytes from main RAM starting at address I.
- XORs each byte into the 64x32 monochrome framebuffer at (X,Y) and reports the VF collision flag.
- Sits between the CHIP-8 core and the VRAM write port; the HDMI path reads the same VRAM on its other port.

---
 rtl/sprite_draw_engine_if.sv | 35 +++
 rtl/sprite_draw_engine.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/sprite_draw_engine_if.sv
`default_nettype none
// ============================================================================
// Module  : sprite_draw_engine_if
// Brief   : Command, main-RAM and VRAM signal bundle for sprite_draw_engine.
// Revision: 1.0
// ============================================================================
interface sprite_draw_engine_if;
  logic        start_in;
  logic [7:0]  x_in;
  logic [7:0]  y_in;
  logic [3:0]  n_in;
  logic [11:0] i_in;
  logic [11:0] mem_addr_out;
  logic [7:0]  mem_data_in;
  logic [15:0] vram_addr_out;
  logic [7:0]  vram_data_in;
  logic [7:0]  vram_data_out;
  logic        vram_we_out;
  logic        busy_out;
  logic        done_out;
  logic        collision_out;

  modport slave (
    input  start_in, x_in, y_in, n_in, i_in, mem_data_in, vram_data_in,
    output mem_addr_out, vram_addr_out, vram_data_out, vram_we_out,
           busy_out, done_out, collision_out
  );

  modport master (
    output start_in, x_in, y_in, n_in, i_in, mem_data_in, vram_data_in,
    input  mem_addr_out, vram_addr_out, vram_data_out, vram_we_out,
           busy_out, done_out, collision_out
  );
endinterface
`default_nettype wire

// File: rtl/sprite_draw_engine.sv
`default_nettype none
// ============================================================================
// Module  : sprite_draw_engine
// Brief   : CHIP-8 DXYN executor: fetches sprite rows, XORs them into VRAM
//           by read-modify-write and reports the VF collision flag.
//           SPRITE_WRAP_EN selects wrapping instead of clipping.
// Revision: 1.0
// ============================================================================
module sprite_draw_engine #(
  parameter int MEM_LATENCY  = 2,
  parameter int VRAM_LATENCY = 2
) (
  input  logic                clk_in,
  input  logic                rst_in,
  sprite_draw_engine_if.slave bus
);

  localparam logic [7:0] c_MEM_WAIT  = 8'(MEM_LATENCY);
  localparam logic [7:0] c_VRAM_WAIT = 8'(VRAM_LATENCY);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_FETCH = 4'd1,
    S_RD0   = 4'd2,
    S_WR0   = 4'd3,
    S_RD1   = 4'd4,
    S_WR1   = 4'd5,
    S_NEXT  = 4'd6,
    S_DONE  = 4'd7
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic [5:0]  r_x0;
  logic [4:0]  r_y0;
  logic [3:0]  r_n;
  logic [3:0]  r_k;
  logic [11:0] r_i;
  logic [7:0]  r_cnt;
  logic [15:0] r_mask;
  logic        r_coll;
  logic [11:0] r_mem_addr;
  logic [15:0] r_vram_addr;
  logic [7:0]  r_wdata;

  logic [7:0]  w_rev;
  logic [4:0]  w_row;
  logic [3:0]  w_k_inc;
  logic        w_need_second;
  logic        w_row_clipped;
  logic        w_last_row;
  logic        w_unused_bits;

  assign w_unused_bits = ^{bus.x_in[7:6], bus.y_in[7:5]};

  // Sprite bytes are MSB-leftmost; VRAM bytes are LSB-leftmost.
  always_comb begin
    w_rev = 8'd0;
    for (int j = 0; j < 8; j++) begin
      w_rev[j] = bus.mem_data_in[7-j];
    end
  end

  assign w_k_inc = r_k + 4'd1;
  assign w_row   = r_y0 + {1'b0, r_k};

`ifdef SPRITE_WRAP_EN
  assign w_row_clipped = 1'b0;
  assign w_need_second = (r_x0[2:0] != 3'd0) && (r_mask[15:8] != 8'd0);
`else
  logic [5:0] w_next_yr;
  assign w_next_yr     = {1'b0, r_y0} + {2'b00, w_k_inc};
  assign w_row_clipped = w_next_yr[5];
  assign w_need_second = (r_x0[2:0] != 3'd0) && (r_mask[15:8] != 8'd0) &&
                         (r_x0[5:3] != 3'd7);
`endif

  assign w_last_row = (w_k_inc == r_n) || w_row_clipped;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (bus.start_in) w_next_state = (bus.n_in == 4'd0) ? S_DONE : S_FETCH;
      S_FETCH: if (r_cnt == c_MEM_WAIT) w_next_state = S_RD0;
      S_RD0:   if (r_cnt == c_VRAM_WAIT) w_next_state = S_WR0;
      S_WR0:   w_next_state = w_need_second ? S_RD1 : S_NEXT;
      S_RD1:   if (r_cnt == c_VRAM_WAIT) w_next_state = S_WR1;
      S_WR1:   w_next_state = S_NEXT;
      S_NEXT:  w_next_state = w_last_row ? S_DONE : S_FETCH;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_x0        <= 6'd0;
      r_y0        <= 5'd0;
      r_n         <= 4'd0;
      r_k         <= 4'd0;
      r_i         <= 12'd0;
      r_cnt       <= 8'd0;
      r_mask      <= 16'd0;
      r_coll      <= 1'b0;
      r_mem_addr  <= 12'd0;
      r_vram_addr <= 16'd0;
      r_wdata     <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start_in) begin
            r_x0   <= bus.x_in[5:0];
            r_y0   <= bus.y_in[4:0];
            r_n    <= bus.n_in;
            r_i    <= bus.i_in;
            r_k    <= 4'd0;
            r_cnt  <= 8'd0;
            r_coll <= 1'b0;
            if (bus.n_in != 4'd0) r_mem_addr <= bus.i_in;
          end
        end
        S_FETCH: begin
          if (r_cnt == c_MEM_WAIT) begin
            r_cnt       <= 8'd0;
            r_mask      <= {8'd0, w_rev} << r_x0[2:0];
            r_vram_addr <= {8'd0, w_row, r_x0[5:3]};
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_RD0: begin
          if (r_cnt == c_VRAM_WAIT) begin
            r_cnt   <= 8'd0;
            r_wdata <= bus.vram_data_in ^ r_mask[7:0];
            r_coll  <= r_coll | (|(bus.vram_data_in & r_mask[7:0]));
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_WR0: begin
          // The 3-bit byte index rolls over to byte 0, which only matters when wrapping.
          if (w_need_second) r_vram_addr <= {8'd0, w_row, r_x0[5:3] + 3'd1};
        end
        S_RD1: begin
          if (r_cnt == c_VRAM_WAIT) begin
            r_cnt   <= 8'd0;
            r_wdata <= bus.vram_data_in ^ r_mask[15:8];
            r_coll  <= r_coll | (|(bus.vram_data_in & r_mask[15:8]));
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_NEXT: begin
          r_k <= w_k_inc;
          if (!w_last_row) r_mem_addr <= r_i + {8'd0, w_k_inc};
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_addr_out  = r_mem_addr;
  assign bus.vram_addr_out = r_vram_addr;
  assign bus.vram_data_out = r_wdata;
  assign bus.vram_we_out   = (r_state == S_WR0) || (r_state == S_WR1);
  assign bus.busy_out      = (r_state != S_IDLE);
  assign bus.done_out      = (r_state == S_DONE);
  assign bus.collision_out = r_coll;

endmodule
`default_nettype wire
